// File: rtl/dft_ram_ctrl.sv
// dft_ram_ctrl: frame controller around a shared DFT RAM.
// Loads a frame of complex samples into the RAM, hands the RAM to the compute
// engine for one run, then streams the results out with valid/ready.
// Optional macro DFT_CTRL_PIPE_EN: 2-entry output buffer in UNLOAD for
// 1 sample/cycle throughput; without it each sample takes two cycles.
module dft_ram_ctrl #(
    parameter int unsigned sample           = 8,
    parameter int unsigned n_bit_for_sample = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_real,
    input  logic [31:0]                 in_imag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_real,
    output logic [31:0]                 out_imag,
    output logic                        out_last,
    output logic                        eng_start,
    input  logic                        eng_done,
    output logic                        ram_grant,
    output logic [1:0]                  ram_wr_sel,
    output logic [1:0]                  ram_rd_sel,
    output logic                        ram_wr_en,
    output logic                        ram_sub_en,
    output logic [n_bit_for_sample-1:0] ram_addr,
    output logic [31:0]                 ram_data_1,
    output logic [31:0]                 ram_data_2,
    input  logic [31:0]                 ram_q_1,
    input  logic [31:0]                 ram_q_2
);

    localparam int unsigned     CW       = n_bit_for_sample + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(sample - 1);

    typedef enum logic [1:0] {LOAD, START, COMPUTE, UNLOAD} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt, cnt_nxt;
    logic                        in_hs, out_hs;
    logic [n_bit_for_sample-1:0] rd_addr;

    // Handshakes and state-decoded control
    assign in_ready   = (state == LOAD);
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign eng_start  = (state == START);
    assign ram_grant  = (state == START) || (state == COMPUTE);
    assign ram_wr_sel = 2'b00;
    assign ram_rd_sel = 2'b10;
    assign ram_sub_en = 1'b1;
    assign ram_wr_en  = in_hs;
    assign ram_data_1 = in_hs ? in_real : '0;
    assign ram_data_2 = in_hs ? in_imag : '0;
    assign out_last   = out_valid && (cnt == LAST_IDX);

    // RAM address: write slot while loading, read slot while unloading
    always_comb begin
        ram_addr = '0;
        case (state)
            LOAD:    ram_addr = cnt[n_bit_for_sample-1:0];
            UNLOAD:  ram_addr = rd_addr;
            default: ram_addr = '0;
        endcase
    end

    // State and sample counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; cnt counts written samples in LOAD and delivered ones in UNLOAD
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD: begin
                if (in_hs) begin
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = START;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            START: state_nxt = COMPUTE;
            COMPUTE: begin
                if (eng_done) begin
                    cnt_nxt   = '0;
                    state_nxt = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_hs) begin
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

`ifdef DFT_CTRL_PIPE_EN
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } sample_t;

    sample_t       obuf [2];
    logic [CW-1:0] iss_ptr;
    logic          inflight;
    logic [1:0]    ocnt;
    logic          head;
    logic          issue;
    logic [2:0]    occ;

    // Issue a read if the buffer will still have room when its data lands
    always_comb begin
        occ   = 3'(ocnt) + 3'(inflight) - 3'(out_hs);
        issue = (state == UNLOAD) && (iss_ptr < CW'(sample)) && (occ < 3'd2);
    end

    assign rd_addr   = iss_ptr[n_bit_for_sample-1:0];
    assign out_valid = (state == UNLOAD) && (ocnt != 2'd0);
    assign out_real  = out_valid ? obuf[head].re : '0;
    assign out_imag  = out_valid ? obuf[head].im : '0;

    // Read issue pointer, in-flight flag and 2-entry output FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_ptr  <= '0;
            inflight <= 1'b0;
            ocnt     <= 2'd0;
            head     <= 1'b0;
            obuf[0]  <= '0;
            obuf[1]  <= '0;
        end else if (state != UNLOAD) begin
            iss_ptr  <= '0;
            inflight <= 1'b0;
            ocnt     <= 2'd0;
            head     <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) iss_ptr <= iss_ptr + 1'b1;
            if (inflight) obuf[head ^ ocnt[0]] <= {ram_q_1, ram_q_2};
            if (out_hs) head <= ~head;
            ocnt <= 2'(ocnt + 2'(inflight) - 2'(out_hs));
        end
    end
`else
    logic rd_phase;

    assign rd_addr   = cnt[n_bit_for_sample-1:0];
    assign out_valid = (state == UNLOAD) && rd_phase;
    assign out_real  = out_valid ? ram_q_1 : '0;
    assign out_imag  = out_valid ? ram_q_2 : '0;

    // Phase 0 presents the address, phase 1 holds RAM data until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_phase <= 1'b0;
        end else if ((state != UNLOAD) || out_hs) begin
            rd_phase <= 1'b0;
        end else begin
            rd_phase <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dft_ram_ctrl.sv
// tb_dft_ram_ctrl: randomized self-checking bench with a behavioural RAM and
// a frame-level reference (written samples in order, results in order).
module tb_dft_ram_ctrl;

    localparam int N = 8;
`ifdef DFT_CTRL_PIPE_EN
    localparam int FIRST_EXP = 2;
    localparam int LAST_EXP  = 9;
`else
    localparam int FIRST_EXP = 1;
    localparam int LAST_EXP  = 15;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, eng_done;
    logic [31:0] in_real, in_imag;
    logic        in_ready, out_valid, out_last, eng_start, ram_grant;
    logic [31:0] out_real, out_imag;
    logic [1:0]  ram_wr_sel, ram_rd_sel;
    logic        ram_wr_en, ram_sub_en;
    logic [2:0]  ram_addr;
    logic [31:0] ram_data_1, ram_data_2, ram_q_1, ram_q_2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] frame_re [N];
    logic [31:0] frame_im [N];
    logic [31:0] x_re [N];
    logic [31:0] x_im [N];

    typedef struct packed {
        logic [2:0]  a;
        logic [31:0] re;
        logic [31:0] im;
    } wr_t;
    wr_t wr_q [$];

    always #5 clk = ~clk;

    dft_ram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
        .out_imag(out_imag), .out_last(out_last),
        .eng_start(eng_start), .eng_done(eng_done), .ram_grant(ram_grant),
        .ram_wr_sel(ram_wr_sel), .ram_rd_sel(ram_rd_sel), .ram_wr_en(ram_wr_en),
        .ram_sub_en(ram_sub_en), .ram_addr(ram_addr),
        .ram_data_1(ram_data_1), .ram_data_2(ram_data_2),
        .ram_q_1(ram_q_1), .ram_q_2(ram_q_2)
    );

    // RAM model: write log for the input bank, registered read of the result bank
    always @(posedge clk) begin
        ram_q_1 <= x_re[ram_addr];
        ram_q_2 <= x_im[ram_addr];
        if (ram_wr_en) wr_q.push_back({ram_addr, ram_data_1, ram_data_2});
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; eng_done = 1'b0;
        in_real = '0; in_imag = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_last, eng_start, ram_grant, ram_wr_en} !== 6'b100000)
            $display("FAIL reset_ctrl got %b want 100000",
                     {in_ready, out_valid, out_last, eng_start, ram_grant, ram_wr_en});
        else n_pass++;
        n_checks++;
        if ({out_real, out_imag} !== 64'd0)
            $display("FAIL reset_data got %h want 0", {out_real, out_imag});
        else n_pass++;
        n_checks++;
        if ({ram_sub_en, ram_rd_sel, ram_wr_sel, ram_addr} !== 8'b1_10_00_000)
            $display("FAIL reset_ram got %b want 11000000",
                     {ram_sub_en, ram_rd_sel, ram_wr_sel, ram_addr});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, eng_start, ram_grant} !== 4'b1000)
            $display("FAIL reset_release got %b want 1000",
                     {in_ready, out_valid, eng_start, ram_grant});
        else n_pass++;
    endtask

    // Load nsamp samples of frame_*; a full frame must be followed by one START cycle
    task automatic load_frame(input bit gaps, input int nsamp);
        int k = 0;
        int budget = 0;
        while (k < nsamp && budget < 300) begin
            @(negedge clk);
            budget++;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_real  = frame_re[k];
            in_imag  = frame_im[k];
            #1;
            n_checks++;
            if ({in_ready, eng_start, ram_grant, out_valid} !== 4'b1000)
                $display("FAIL load_ctrl k=%0d got %b want 1000", k,
                         {in_ready, eng_start, ram_grant, out_valid});
            else n_pass++;
            n_checks++;
            if (ram_wr_en !== in_valid)
                $display("FAIL load_wr_en k=%0d got %b want %b", k, ram_wr_en, in_valid);
            else n_pass++;
            if (in_valid) begin
                n_checks++;
                if ({ram_addr, ram_wr_sel, ram_sub_en, ram_data_1, ram_data_2} !==
                    {3'(k), 2'b00, 1'b1, frame_re[k], frame_im[k]})
                    $display("FAIL load_write k=%0d got addr %0d data %h/%h want addr %0d data %h/%h",
                             k, ram_addr, ram_data_1, ram_data_2, k, frame_re[k], frame_im[k]);
                else n_pass++;
                k++;
            end
        end
        if (k < nsamp) begin
            n_checks++;
            $display("FAIL load_timeout got %0d samples want %0d", k, nsamp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (nsamp == N) begin
            n_checks++;
            if ({eng_start, ram_grant, in_ready, ram_wr_en} !== 4'b1100)
                $display("FAIL start_pulse got %b want 1100",
                         {eng_start, ram_grant, in_ready, ram_wr_en});
            else n_pass++;
            @(negedge clk);
            #1;
            n_checks++;
            if ({eng_start, ram_grant, in_ready} !== 3'b010)
                $display("FAIL start_single got %b want 010", {eng_start, ram_grant, in_ready});
            else n_pass++;
        end
    endtask

    // Compare the RAM write log against the frame that was sent
    task automatic test_write_log(input int nsamp);
        n_checks++;
        if (wr_q.size() !== nsamp)
            $display("FAIL write_count got %0d want %0d", wr_q.size(), nsamp);
        else n_pass++;
        for (int k = 0; k < nsamp && k < wr_q.size(); k++) begin
            n_checks++;
            if (wr_q[k] !== {3'(k), frame_re[k], frame_im[k]})
                $display("FAIL write_log k=%0d got %h want %h", k, wr_q[k],
                         {3'(k), frame_re[k], frame_im[k]});
            else n_pass++;
        end
    endtask

    // Hold the engine busy (inputs offered meanwhile), then pulse eng_done
    task automatic test_compute(input int hold);
        eng_done = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({ram_grant, in_ready, out_valid, ram_wr_en, eng_start, ram_addr} !== 8'b10000_000)
                $display("FAIL compute_hold cyc=%0d got %b want 10000000", i,
                         {ram_grant, in_ready, out_valid, ram_wr_en, eng_start, ram_addr});
            else n_pass++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        eng_done = 1'b1;
        #1;
        n_checks++;
        if ({ram_grant, out_valid} !== 2'b10)
            $display("FAIL compute_done got %b want 10", {ram_grant, out_valid});
        else n_pass++;
    endtask

    // Drain the result frame; cycle 0 of the loop is the first UNLOAD cycle
    task automatic test_unload(input bit rnd_ready, input bit done_lvl);
        int idx = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [64:0] prev = '0;
        logic exp_last;
        while (idx < N && cyc < 400) begin
            @(negedge clk);
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            eng_done  = done_lvl;
            #1;
            n_checks++;
            if ({ram_grant, in_ready, ram_wr_en, eng_start, ram_sub_en, ram_rd_sel, ram_wr_sel}
                !== 9'b0000_1_10_00)
                $display("FAIL unload_ctrl cyc=%0d got %b want 000011000", cyc,
                         {ram_grant, in_ready, ram_wr_en, eng_start, ram_sub_en, ram_rd_sel, ram_wr_sel});
            else n_pass++;
            if (pv && !pr) begin
                n_checks++;
                if ({out_valid, out_real, out_imag, out_last} !== {1'b1, prev})
                    $display("FAIL stall_hold cyc=%0d got %h want %h", cyc,
                             {out_valid, out_real, out_imag, out_last}, {1'b1, prev});
                else n_pass++;
            end
            if (!out_valid) begin
                n_checks++;
                if (out_last !== 1'b0)
                    $display("FAIL last_idle cyc=%0d got %b want 0", cyc, out_last);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                exp_last = (idx == N - 1);
                n_checks++;
                if ({out_real, out_imag, out_last} !== {x_re[idx], x_im[idx], exp_last})
                    $display("FAIL unload_data idx=%0d got %h/%h last %b want %h/%h last %b",
                             idx, out_real, out_imag, out_last, x_re[idx], x_im[idx], exp_last);
                else n_pass++;
                if (first < 0) first = cyc;
                last = cyc;
                idx++;
            end
            pv   = out_valid;
            pr   = out_ready;
            prev = {out_real, out_imag, out_last};
            cyc++;
        end
        if (idx < N) begin
            n_checks++;
            $display("FAIL unload_timeout got %0d samples want %0d", idx, N);
        end
        if (!rnd_ready) begin
            n_checks++;
            if (first !== FIRST_EXP || last !== LAST_EXP)
                $display("FAIL unload_timing got first %0d last %0d want first %0d last %0d",
                         first, last, FIRST_EXP, LAST_EXP);
            else n_pass++;
        end
        @(negedge clk);
        eng_done  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, ram_grant, eng_start} !== 4'b1000)
            $display("FAIL back_to_load got %b want 1000",
                     {in_ready, out_valid, ram_grant, eng_start});
        else n_pass++;
    endtask

    task automatic test_directed_frame();
        for (int k = 0; k < N; k++) begin
            frame_re[k] = 32'(k);
            frame_im[k] = 32'(-k);
            x_re[k]     = 32'(100 + k);
            x_im[k]     = 32'(200 + k);
        end
        wr_q.delete();
        load_frame(1'b0, N);
        test_write_log(N);
        test_compute(50);
        test_write_log(N);
        test_unload(1'b0, 1'b0);
    endtask

    task automatic test_eng_done_ignored();
        eng_done = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({in_ready, eng_start, ram_grant, out_valid} !== 4'b1000)
                $display("FAIL done_in_load cyc=%0d got %b want 1000", i,
                         {in_ready, eng_start, ram_grant, out_valid});
            else n_pass++;
        end
        eng_done = 1'b0;
        for (int k = 0; k < N; k++) begin
            frame_re[k] = $urandom;
            frame_im[k] = $urandom;
            x_re[k]     = $urandom;
            x_im[k]     = $urandom;
        end
        wr_q.delete();
        load_frame(1'b1, N);
        test_write_log(N);
        test_compute(5);
        test_unload(1'b1, 1'b1);
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < N; k++) begin
            frame_re[k] = $urandom;
            frame_im[k] = $urandom;
        end
        wr_q.delete();
        load_frame(1'b1, 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_write_log(5);
        for (int k = 0; k < N; k++) begin
            frame_re[k] = $urandom;
            frame_im[k] = $urandom;
            x_re[k]     = $urandom;
            x_im[k]     = $urandom;
        end
        wr_q.delete();
        load_frame(1'b1, N);
        test_write_log(N);
        test_compute(3);
        test_unload(1'b1, 1'b0);
        // Reset while the engine owns the RAM
        load_frame(1'b0, N);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, ram_grant, eng_start, out_valid} !== 4'b1000)
            $display("FAIL reset_compute got %b want 1000",
                     {in_ready, ram_grant, eng_start, out_valid});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed_frame();
        test_eng_done_ignored();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dft_ram_ctrl.md
DFT_RAM_CTRL -- requirements
Module: dft_ram_ctrl

Interface
REQ-001 SHALL have parameter sample, default 8, points per frame.
REQ-002 SHALL have parameter n_bit_for_sample, default 3, address width (log2 sample).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid  in  1, in_ready  out  1, in_real  in  32, in_imag  in  32: signed input sample stream.
REQ-006 SHALL have ports out_valid  out  1, out_ready  in  1, out_real  out  32, out_imag  out  32, out_last  out  1: signed result stream.
REQ-007 SHALL have ports eng_start  out  1 (one-cycle pulse), eng_done  in  1, ram_grant  out  1: the compute engine owns the RAM while ram_grant=1.
REQ-008 SHALL have RAM-master ports ram_wr_sel  out  2, ram_rd_sel  out  2, ram_wr_en  out  1, ram_sub_en  out  1, ram_addr  out  n_bit_for_sample, ram_data_1  out  32, ram_data_2  out  32.
REQ-009 SHALL have ports ram_q_1  in  32 and ram_q_2  in  32; RAM read data is registered, 1-cycle latency, and is re-read every cycle.

Function
REQ-010 SHALL implement states LOAD, START, COMPUTE, UNLOAD; a sample counter cnt of width n_bit_for_sample+1.
REQ-011 LOAD: in_ready=1; on in_valid&in_ready SHALL drive combinationally ram_wr_en=1, ram_sub_en=1, ram_wr_sel=2'b00, ram_addr=cnt, ram_data_1=in_real, ram_data_2=in_imag, then cnt++.
REQ-012 LOAD: on the handshake with cnt=sample-1 SHALL clear cnt and go to START; ram_wr_en=0 in all cycles without a LOAD handshake.
REQ-013 START: SHALL assert eng_start=1 and ram_grant=1 for exactly one cycle, then go to COMPUTE.
REQ-014 COMPUTE: SHALL hold ram_grant=1, in_ready=0, out_valid=0; on eng_done=1 SHALL go to UNLOAD with cnt=0, ram_grant falls the next cycle.
REQ-015 eng_done SHALL be ignored outside COMPUTE.
REQ-016 UNLOAD: SHALL drive ram_rd_sel=2'b10, ram_sub_en=1, ram_addr=read pointer; out_real=X_real, out_imag=X_imag of that address.
REQ-017 out_last SHALL be 1 only with the sample at address sample-1; after its handshake SHALL return to LOAD with cnt=0.
REQ-018 out_valid SHALL never deassert, and out_real/out_imag/out_last SHALL not change, while out_valid=1 and out_ready=0.
REQ-019 Outside LOAD, in_ready SHALL be 0; outside UNLOAD, out_valid SHALL be 0.
REQ-020 ram_wr_en SHALL be 0 whenever ram_grant=1.
REQ-021 In every state, ram_sub_en SHALL be 1 and ram_rd_sel/ram_wr_sel SHALL remain 2'b10/2'b00; ram_addr SHALL be 0 outside LOAD and UNLOAD.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force state LOAD, cnt=0, read pointer 0, output buffer empty.
REQ-023 During/after reset: in_ready=1 (first cycle after release), out_valid=0, out_last=0, out_real=0, out_imag=0, eng_start=0, ram_grant=0, ram_wr_en=0.
REQ-024 Reset mid-frame in any state SHALL discard the partial frame without further RAM writes; the next frame restarts at address 0.

Configuration
REQ-025 Macro DFT_CTRL_PIPE_EN defined: UNLOAD SHALL use a 2-entry output buffer, issue a read whenever buffered+in-flight < 2, sustain 1 sample/cycle with out_ready=1, first out_valid 2 cycles after entering UNLOAD.
REQ-026 Macro DFT_CTRL_PIPE_EN undefined: no buffer; ram_addr held per sample; out_valid=1 from the cycle after ram_addr changes, out_real/out_imag taken directly from ram_q_1/ram_q_2; maximum 1 sample per 2 cycles.

Verification
REQ-027 Load 8 samples (real=k, imag=-k, k=0..7), in_valid=1 continuous -> 8 consecutive writes, addr 0..7, wr_sel=00, sub_en=1, then eng_start pulse 1 cycle.
REQ-028 Hold eng_done=0 for 50 cycles after start -> ram_grant=1, in_ready=0, out_valid=0 throughout; eng_done=1 pulse -> UNLOAD entered next cycle.
REQ-029 RAM model X_real[k]=100+k, X_imag[k]=200+k, out_ready=1 -> outputs (100,200)..(107,207) in order, out_last only on (107,207); with PIPE_EN 8 consecutive cycles, without 16 cycles.
REQ-030 out_ready toggled randomly in UNLOAD -> no sample lost, duplicated or changed while stalled.
REQ-031 rst_n=0 for 1 cycle after 5 loaded samples, then full new frame -> writes restart at addr 0, no eng_start until 8 new samples.
REQ-032 eng_done=1 during LOAD and UNLOAD -> no state change, no eng_start.
